// File: rtl/io_read_hub.sv
// Multi-channel debounced input hub answering memorio reads; optional press latching under IOREAD_STICKY_EN.
// Latency: 2 sync + DB_CYCLES debounce before a pin change is readable; a read returns data one cycle after ior.
// Backpressure: none; every ior with a non-empty select completes with a one-cycle valid pulse.
module io_read_hub #(
    parameter int                CH_NUM      = 2,
    parameter int                DATA_W      = 16,
    parameter int                DB_CYCLES   = 20000,
    parameter int                DB_W        = 16,
    parameter logic [CH_NUM-1:0] STICKY_MASK = '0
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     ior,
    input  logic [CH_NUM-1:0]        io_sel,
    input  logic [CH_NUM*DATA_W-1:0] io_raw,
    output logic [DATA_W-1:0]        ioread_data,
    output logic                     ioread_valid,
    output logic                     sel_err
);

`ifdef IOREAD_STICKY_EN
    localparam logic STICKY_ON = 1'b1;
`else
    localparam logic STICKY_ON = 1'b0;
`endif
    localparam logic [CH_NUM-1:0] STICKY_CH = STICKY_MASK & {CH_NUM{STICKY_ON}};
    localparam logic [DB_W-1:0]   CNT_LAST  = DB_W'(DB_CYCLES - 1);

    logic [CH_NUM-1:0][DATA_W-1:0] view;
    logic [CH_NUM-1:0]             rd_hit;
    logic                          multi_sel;
    logic [DATA_W-1:0]             rd_word;

    // rd_hit isolates the lowest set select bit, so overlapping selects still pick one channel.
    always_comb begin
        rd_hit    = io_sel & (~io_sel + CH_NUM'(1));
        multi_sel = |(io_sel & (io_sel - CH_NUM'(1)));
        rd_word   = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            if (rd_hit[i]) rd_word = rd_word | view[i];
        end
    end

    for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
        logic [DATA_W-1:0] sync1;
        logic [DATA_W-1:0] sync2;
        logic [DATA_W-1:0] stable;
        logic [DB_W-1:0]   cnt;
        logic              accept;

        assign accept = (sync2 != stable) && (cnt == CNT_LAST);

        always_ff @(posedge clock) begin
            if (reset) begin
                sync1  <= '0;
                sync2  <= '0;
                stable <= '0;
                cnt    <= '0;
            end else begin
                sync1 <= io_raw[i*DATA_W +: DATA_W];
                sync2 <= sync1;
                if (sync2 == stable) begin
                    cnt <= '0;
                end else if (accept) begin
                    stable <= sync2;
                    cnt    <= '0;
                end else begin
                    cnt <= cnt + DB_W'(1);
                end
            end
        end

        if (STICKY_CH[i]) begin : g_sticky
            logic [DATA_W-1:0] sticky;
            logic [DATA_W-1:0] rise;

            assign rise = accept ? (sync2 & ~stable) : '0;

            // A rise landing on the clearing read survives into the next read.
            always_ff @(posedge clock) begin
                if (reset) begin
                    sticky <= '0;
                end else if (ior && rd_hit[i]) begin
                    sticky <= rise;
                end else begin
                    sticky <= sticky | rise;
                end
            end

            assign view[i] = stable | sticky;
        end else begin : g_plain
            assign view[i] = stable;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ioread_data  <= '0;
            ioread_valid <= 1'b0;
            sel_err      <= 1'b0;
        end else begin
            ioread_valid <= 1'b0;
            sel_err      <= 1'b0;
            if (ior && (|io_sel)) begin
                ioread_data  <= rd_word;
                ioread_valid <= 1'b1;
                sel_err      <= multi_sel;
            end
        end
    end

endmodule

// File: tb/tb_io_read_hub.sv
// Scoreboard bench for io_read_hub: reference model predicts every cycle's outputs, monitor compares on the falling edge.
module tb_io_read_hub;
    localparam int              CH_NUM      = 2;
    localparam int              DATA_W      = 16;
    localparam int              DB_CYCLES   = 4;
    localparam int              DB_W        = 8;
    localparam logic [1:0]      STICKY_MASK = 2'b10;
`ifdef IOREAD_STICKY_EN
    localparam bit              STICKY_ON   = 1'b1;
`else
    localparam bit              STICKY_ON   = 1'b0;
`endif

    logic                     clock = 1'b0;
    logic                     reset = 1'b1;
    logic                     ior = 1'b0;
    logic [CH_NUM-1:0]        io_sel = '0;
    logic [CH_NUM*DATA_W-1:0] io_raw = '0;
    logic [DATA_W-1:0]        ioread_data;
    logic                     ioread_valid;
    logic                     sel_err;

    io_read_hub #(
        .CH_NUM(CH_NUM), .DATA_W(DATA_W), .DB_CYCLES(DB_CYCLES),
        .DB_W(DB_W), .STICKY_MASK(STICKY_MASK)
    ) dut (
        .clock(clock), .reset(reset), .ior(ior), .io_sel(io_sel), .io_raw(io_raw),
        .ioread_data(ioread_data), .ioread_valid(ioread_valid), .sel_err(sel_err)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] data;
        logic              err;
    } resp_t;

    resp_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: sync delay line, mismatch run length per channel, latched presses.
    logic [DATA_W-1:0] m_s1[CH_NUM];
    logic [DATA_W-1:0] m_s2[CH_NUM];
    logic [DATA_W-1:0] m_stable[CH_NUM];
    logic [DATA_W-1:0] m_sticky[CH_NUM];
    int                m_run[CH_NUM];
    resp_t             m_out;
    bit                started = 1'b0;

    always @(posedge clock) begin
        if (reset) begin
            for (int c = 0; c < CH_NUM; c++) begin
                m_s1[c] = '0; m_s2[c] = '0; m_stable[c] = '0; m_sticky[c] = '0; m_run[c] = 0;
            end
            m_out   = '0;
            started = 1'b1;
        end else if (started) begin
            int          idx;
            bit          rd;
            logic [DATA_W-1:0] rise;
            rd  = ior && (io_sel != '0);
            idx = 0;
            for (int c = CH_NUM - 1; c >= 0; c--) if (io_sel[c]) idx = c;
            m_out.valid = rd;
            m_out.err   = rd && ($countones(io_sel) > 1);
            if (rd) m_out.data = m_stable[idx] | m_sticky[idx];
            for (int c = 0; c < CH_NUM; c++) begin
                rise = '0;
                if (m_s2[c] == m_stable[c]) begin
                    m_run[c] = 0;
                end else if (m_run[c] + 1 == DB_CYCLES) begin
                    rise        = m_s2[c] & ~m_stable[c];
                    m_stable[c] = m_s2[c];
                    m_run[c]    = 0;
                end else begin
                    m_run[c] = m_run[c] + 1;
                end
                if (STICKY_ON && STICKY_MASK[c]) begin
                    if (rd && idx == c) m_sticky[c] = rise;
                    else                m_sticky[c] = m_sticky[c] | rise;
                end
                m_s2[c] = m_s1[c];
                m_s1[c] = io_raw[c*DATA_W +: DATA_W];
            end
        end
        if (started) exp_q.push_back(m_out);
    end

    always @(negedge clock) begin
        resp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("sb_valid", 32'(ioread_valid), 32'(e.valid));
            check("sb_data",  32'(ioread_data),  32'(e.data));
            check("sb_err",   32'(sel_err),      32'(e.err));
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        logic [DATA_W-1:0] v;

        // Reset then read
        cycles(2);
        reset = 1'b0; ior = 1'b1; io_sel = 2'b01;
        cycles(1);
        check("t1_data",  32'(ioread_data), 32'h0000);
        check("t1_valid", 32'(ioread_valid), 32'd1);
        check("t1_err",   32'(sel_err), 32'd0);

        // Debounce latency, reads held back-to-back from the capture edge
        io_raw[15:0] = 16'hA5A5;
        for (int j = 0; j <= 6; j++) begin
            cycles(1);
            check("t2_valid", 32'(ioread_valid), 32'd1);
            if (j == 5) check("t2_before", 32'(ioread_data), 32'h0000);
            if (j == 6) check("t2_after",  32'(ioread_data), 32'hA5A5);
        end

        // Bounce reject on ch1
        io_sel = 2'b10;
        for (int j = 0; j < 20; j++) begin
            io_raw[16] = ((j / 2) % 2 == 0);
            cycles(1);
            check("t3_bounce", 32'(ioread_data), 32'h0000);
        end
        io_raw[31:16] = 16'h0000;
        cycles(6);
        check("t3_rest", 32'(ioread_data), 32'h0000);

        // Selection priority and error pulse
        ior = 1'b0;
        io_raw = {16'h2222, 16'h1111};
        cycles(10);
        ior = 1'b1; io_sel = 2'b10;
        cycles(1);
        check("t4_sel10", 32'(ioread_data), 32'h2222);
        check("t4_err10", 32'(sel_err), 32'd0);
        io_sel = 2'b11;
        cycles(1);
        check("t4_sel11", 32'(ioread_data), 32'h1111);
        check("t4_err11", 32'(sel_err), 32'd1);
        io_sel = 2'b00;
        cycles(1);
        check("t4_hold",   32'(ioread_data), 32'h1111);
        check("t4_novld",  32'(ioread_valid), 32'd0);
        check("t4_noerr",  32'(sel_err), 32'd0);

        // Reset while ch0 debounce counter sits at 2 and a read is requested
        ior = 1'b0;
        io_raw[15:0] = 16'h5555;
        cycles(4);
        reset = 1'b1; ior = 1'b1; io_sel = 2'b01;
        cycles(1);
        check("t5_rst_vld",  32'(ioread_valid), 32'd0);
        check("t5_rst_data", 32'(ioread_data), 32'h0000);
        reset = 1'b0;
        cycles(1);
        check("t5_read", 32'(ioread_data), 32'h0000);

        // Press latching on ch1
        ior = 1'b0; io_sel = 2'b00;
        io_raw = '0;
        cycles(12);
        ior = 1'b1; io_sel = 2'b10;
        cycles(1);
        ior = 1'b0;
        cycles(2);
        io_raw[16] = 1'b1;
        cycles(6);
        io_raw[16] = 1'b0;
        cycles(12);
        ior = 1'b1; io_sel = 2'b10;
        cycles(1);
        check("t6_first", 32'(ioread_data), STICKY_ON ? 32'h0001 : 32'h0000);
        cycles(1);
        check("t6_second", 32'(ioread_data), 32'h0000);
        ior = 1'b0;

        // Randomised traffic against the model
        for (int i = 0; i < 2500; i++) begin
            @(negedge clock);
            reset = ($urandom_range(0, 299) == 0);
            for (int c = 0; c < CH_NUM; c++) begin
                if ($urandom_range(0, 5) == 0) begin
                    v = io_raw[c*DATA_W +: DATA_W];
                    case ($urandom_range(0, 2))
                        0:       v = '0;
                        1:       v = DATA_W'($urandom);
                        default: v = v ^ (DATA_W'(1) << $urandom_range(0, DATA_W - 1));
                    endcase
                    io_raw[c*DATA_W +: DATA_W] = v;
                end
            end
            ior    = ($urandom_range(0, 2) != 0);
            io_sel = CH_NUM'($urandom_range(0, 3));
        end
        reset = 1'b0; ior = 1'b0;
        cycles(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
